// File: rtl/accel_frame_rx.sv
// Multi-channel accelerometer frame receiver: sync hunt, MS-first sample assembly,
// optional XOR checksum, intra-frame timeout and a double-buffered measurement bus.
module accel_frame_rx #(
  parameter int         DATA_W    = 14,
  parameter int         NUM_CH    = 3,
  parameter bit         SYNC_EN   = 1'b1,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter bit         CHK_EN    = 1'b1,
  parameter int         TIMEOUT   = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic [7:0]               rx_data,
  output logic                     clr_rdy,
  output logic [NUM_CH*DATA_W-1:0] meas,
  output logic                     meas_vld,
  output logic                     frame_stb,
  output logic                     chk_err,
  output logic                     tmo_err,
  output logic [7:0]               err_cnt
);

  localparam int BYTES = (DATA_W + 7) / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(NUM_CH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHK} state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             byte_q, byte_d;
  logic [CW-1:0]             ch_q, ch_d;
  logic [7:0]                xor_q, xor_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic [NUM_CH*DATA_W-1:0]  shadow_q, shadow_d;
  logic [NUM_CH*DATA_W-1:0]  meas_q, meas_d;
  logic                      meas_vld_q, meas_vld_d;
  logic                      frame_stb_q, frame_stb_d;
  logic                      chk_err_q, chk_err_d;
  logic                      tmo_err_q, tmo_err_d;
  logic [7:0]                err_cnt_q, err_cnt_d;
  logic                      data_s, commit_s, restart_s;

  // UART_rx never stalls: every offered byte is consumed in its own cycle.
  assign clr_rdy = rdy;

  // Frame sequencing, shadow assembly, checksum, timeout and commit.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    ch_d        = ch_q;
    xor_d       = xor_q;
    tmo_d       = tmo_q;
    shadow_d    = shadow_q;
    meas_d      = meas_q;
    meas_vld_d  = meas_vld_q;
    err_cnt_d   = err_cnt_q;
    frame_stb_d = 1'b0;
    chk_err_d   = 1'b0;
    tmo_err_d   = 1'b0;
    data_s      = 1'b0;
    commit_s    = 1'b0;
    restart_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (rdy && SYNC_EN) begin
          if (rx_data == SYNC_BYTE) begin
            state_d   = S_DATA;
            restart_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (rdy) begin
          data_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (rdy) begin
          data_s = 1'b1;
          tmo_d  = '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d  = 1'b1;
          meas_vld_d = 1'b0;
          restart_s  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHK: begin
        if (rdy) begin
          restart_s = 1'b1;
          state_d   = S_IDLE;
          if (rx_data == xor_q) begin
            commit_s = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d  = 1'b1;
          meas_vld_d = 1'b0;
          restart_s  = 1'b1;
          state_d    = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        restart_s = 1'b1;
        state_d   = S_IDLE;
      end
    endcase

    // Sample bit p lives in byte BYTES-1-p/8 (MS first); MS-byte bits beyond DATA_W are dropped.
    if (data_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int p = 0; p < DATA_W; p++) begin
          if ((ch_q == CW'(c)) && (byte_q == BW'(BYTES - 1 - p / 8))) begin
            shadow_d[c*DATA_W + p] = rx_data[p % 8];
          end else begin
            shadow_d[c*DATA_W + p] = shadow_q[c*DATA_W + p];
          end
        end
      end
      xor_d = xor_q ^ rx_data;
      if (byte_q == BYTE_LAST) begin
        byte_d = '0;
        if (ch_q == CH_LAST) begin
          ch_d = '0;
          if (CHK_EN) begin
            state_d = S_CHK;
          end else begin
            commit_s = 1'b1;
            xor_d    = 8'h00;
            state_d  = S_IDLE;
          end
        end else begin
          ch_d    = ch_q + CW'(1);
          state_d = S_DATA;
        end
      end else begin
        byte_d  = byte_q + BW'(1);
        state_d = S_DATA;
      end
    end else if (restart_s) begin
      byte_d = '0;
      ch_d   = '0;
      xor_d  = 8'h00;
      tmo_d  = '0;
    end else begin
      byte_d = byte_q;
    end

    // Commit reads shadow_d so the final byte lands in meas on its own accept edge.
    if (commit_s) begin
      meas_d      = shadow_d;
      meas_vld_d  = 1'b1;
      frame_stb_d = 1'b1;
    end else begin
      meas_d = meas_q;
    end

    if ((chk_err_d || tmo_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_q      <= '0;
      ch_q        <= '0;
      xor_q       <= 8'h00;
      tmo_q       <= '0;
      shadow_q    <= '0;
      meas_q      <= '0;
      meas_vld_q  <= 1'b0;
      frame_stb_q <= 1'b0;
      chk_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      ch_q        <= ch_d;
      xor_q       <= xor_d;
      tmo_q       <= tmo_d;
      shadow_q    <= shadow_d;
      meas_q      <= meas_d;
      meas_vld_q  <= meas_vld_d;
      frame_stb_q <= frame_stb_d;
      chk_err_q   <= chk_err_d;
      tmo_err_q   <= tmo_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign meas      = meas_q;
  assign meas_vld  = meas_vld_q;
  assign frame_stb = frame_stb_q;
  assign chk_err   = chk_err_q;
  assign tmo_err   = tmo_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
